simon_core_n: RTL and testbench
===============================

// Module: simon_core_n
// PURPOSE
//  Parametrised Simon game engine: generalises the fixed 4-button game to NUM_BTNS channels
//  and a configurable maximum sequence length.
//  Adds a fast mode, an input timeout, a win state and a reset-persistent high score.
//  Sits between the debouncers/LFSR/tick divider and the LED and 7-seg drivers.
//  Stores the pattern internally; no external pattern memory.
// PARAMETERS
//  NUM_BTNS       4    button/LED channels; power of two, 2..8
//  MAX_LEN        32   longest sequence; 1..99. Reaching it wins the game.
//  ON_TICKS       50   LED on-time per playback step, in ticks (>=2)
//  OFF_TICKS      25   LED gap between playback steps, in ticks (>=1)
//  TIMEOUT_TICKS  300  ticks allowed between player presses before a fail
//  RESULT_TICKS   100  ticks the success LED is held before the next round
// PORTS
//  clk          in   1         system clock
//  rst_n        in   1         asynchronous active-low reset
//  tick         in   1         one-clk-wide time-base pulse (100 Hz)
//  btn_pulse    in   NUM_BTNS  one-clk-wide debounced press pulses
//  rnd          in   8         free-running LFSR value
//  start        in   1         one-clk-wide start/restart pulse
//  mode_fast    in   1         fast mode; sampled only when start is accepted
//  game_leds    out  NUM_BTNS  playback and echo LEDs, one-hot or zero
//  led_success  out  1         round-passed / win indicator
//  led_fail     out  1         game-over indicator
//  score_bcd    out  8         completed rounds, two BCD digits {tens,units}
//  high_bcd     out  8         best score since reset, two BCD digits
//  busy         out  1         high in every state except IDLE, FAIL and WIN
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; length, index, timers and stored pattern cleared.
//  Reset is honoured asynchronously in any state, including mid-playback and mid-input.
//  All timers advance only on cycles where tick=1. Other logic is clocked every clk.
//  Lengths: IDXW=log2(NUM_BTNS). New step = rnd[IDXW-1:0], taken in ADD.
//   Pattern is held in a MAX_LEN x IDXW register array.
//  Fast mode: effective on/off times are ON_TICKS>>1 and OFF_TICKS>>1, each floored at 1.
//  FSM states:
//   IDLE/FAIL/WIN: start -> clear length/score, latch mode_fast, go to ADD.
//    All other inputs are ignored.
//   ADD (1 clk): pattern[len] <= new step; len <= len+1; idx <= 0 -> SHOW_ON.
//   SHOW_ON: game_leds = onehot(pattern[idx]) for the on-time, then -> SHOW_OFF.
//   SHOW_OFF: LEDs 0 for the off-time. If idx < len-1, idx++ and -> SHOW_ON.
//    Otherwise idx <= 0, reset the timeout and -> WAIT_IN.
//   WAIT_IN: waits for exactly one bit set in btn_pulse.
//    Correct press: -> ECHO (LED lit for 1 on-time; later presses in ECHO are ignored).
//    Wrong button, or more than one bit set in the same cycle: -> FAIL.
//    TIMEOUT_TICKS ticks without a press: -> FAIL. The timer restarts after every accepted press.
//   ECHO end: if idx < len-1, idx++ and -> WAIT_IN.
//    Otherwise score <= len. If len==MAX_LEN -> WIN, else -> SUCCESS.
//   SUCCESS: led_success=1 for RESULT_TICKS, then -> ADD.
//   FAIL: led_fail=1 and game_leds=0 until the next start.
//   WIN: led_success=1 and game_leds all ones until the next start.
//  score_bcd changes only in the cycle after a round completes, and on start (cleared to 0x00).
//  High score: on entry to FAIL or WIN, if score > high, then high <= score.
//   high_bcd is not cleared by start, only by rst_n.
//  Binary-to-BCD conversion is combinational from the 7-bit counters. Values never exceed 99.
//  btn_pulse in any state other than WAIT_IN is ignored and does not change the score.
// TESTING
//  Reset mid-SHOW_ON (NUM_BTNS=4) -> all outputs 0 and state IDLE on the next clk;
//   high_bcd=0x00.
//  start with rnd[1:0]=2 and a correct echo on btn 2 -> LED2 lit for 50 ticks;
//   after the echo, score_bcd=0x01 and led_success is held for 100 ticks.
//  Round 3: correct, correct, then a wrong button -> led_fail=1, score_bcd=0x02, high_bcd=0x02.
//  WAIT_IN with no press for 300 ticks -> FAIL.
//   btn_pulse=4'b0011 in WAIT_IN -> FAIL in the same round.
//  mode_fast=1 at start -> on=25 ticks, off=12 ticks.
//   Toggling mode_fast mid-game has no effect.
//  MAX_LEN=3, all rounds correct -> WIN: score_bcd=0x03, game_leds=4'hF.
//   A later start clears the score and keeps high_bcd=0x03.

Source files
------------

// File: rtl/simon_core_n.sv
// Parametrised Simon game engine: plays back a growing random pattern, checks the
// player's echo, tracks score and a reset-persistent high score in BCD.
module simon_core_n #(
  parameter int NUM_BTNS      = 4,
  parameter int MAX_LEN       = 32,
  parameter int ON_TICKS      = 50,
  parameter int OFF_TICKS     = 25,
  parameter int TIMEOUT_TICKS = 300,
  parameter int RESULT_TICKS  = 100
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic [NUM_BTNS-1:0] btn_pulse,
  input  logic [7:0]          rnd,
  input  logic                start,
  input  logic                mode_fast,
  output logic [NUM_BTNS-1:0] game_leds,
  output logic                led_success,
  output logic                led_fail,
  output logic [7:0]          score_bcd,
  output logic [7:0]          high_bcd,
  output logic                busy
);

  localparam int IDXW   = $clog2(NUM_BTNS);
  localparam int PW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW     = 16;
  localparam int ON_FI  = (ON_TICKS / 2 < 1) ? 1 : ON_TICKS / 2;
  localparam int OFF_FI = (OFF_TICKS / 2 < 1) ? 1 : OFF_TICKS / 2;

  localparam logic [TW-1:0] ON_N  = TW'(ON_TICKS);
  localparam logic [TW-1:0] OFF_N = TW'(OFF_TICKS);
  localparam logic [TW-1:0] ON_F  = TW'(ON_FI);
  localparam logic [TW-1:0] OFF_F = TW'(OFF_FI);
  localparam logic [TW-1:0] TO_N  = TW'(TIMEOUT_TICKS);
  localparam logic [TW-1:0] RES_N = TW'(RESULT_TICKS);
  localparam logic [6:0]    MAX_L = 7'(MAX_LEN);

  typedef enum logic [3:0] {
    S_IDLE, S_ADD, S_SHOW_ON, S_SHOW_OFF, S_WAIT_IN, S_ECHO, S_SUCCESS, S_FAIL, S_WIN
  } state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   timer;
  logic [TW-1:0]   limit;
  logic            t_done;
  logic [6:0]      idx, len, score, high;
  logic            fast;
  logic [IDXW-1:0] pattern [2**PW];
  logic [NUM_BTNS-1:0] cur_led;
  logic            last;
  logic            press_any, press_ok;
  logic            unused_rnd;

  function automatic logic [NUM_BTNS-1:0] onehot(input logic [IDXW-1:0] s);
    onehot = NUM_BTNS'(1) << s;
  endfunction

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [6:0] tens, units;
    tens   = v / 7'd10;
    units  = v - tens * 7'd10;
    to_bcd = {tens[3:0], units[3:0]};
  endfunction

  // Upper LFSR bits are deliberately discarded; only the low IDXW bits pick a button.
  assign unused_rnd = ^rnd[7:IDXW];

  assign cur_led   = onehot(pattern[idx[PW-1:0]]);
  assign last      = (idx == len - 7'd1);
  assign press_any = |btn_pulse;
  assign press_ok  = $onehot(btn_pulse) && (btn_pulse == cur_led);

  always_comb begin
    state_nxt = state;
    limit     = TW'(1);
    case (state)
      S_SHOW_ON, S_ECHO: limit = fast ? ON_F : ON_N;
      S_SHOW_OFF:        limit = fast ? OFF_F : OFF_N;
      S_WAIT_IN:         limit = TO_N;
      S_SUCCESS:         limit = RES_N;
      default:           limit = TW'(1);
    endcase
    t_done = tick && (timer == limit - TW'(1));
    case (state)
      S_IDLE, S_FAIL, S_WIN: if (start) state_nxt = S_ADD;
      S_ADD:      state_nxt = S_SHOW_ON;
      S_SHOW_ON:  if (t_done) state_nxt = S_SHOW_OFF;
      S_SHOW_OFF: if (t_done) state_nxt = last ? S_WAIT_IN : S_SHOW_ON;
      S_WAIT_IN: begin
        // A press always wins over a timeout expiring in the same cycle.
        if (press_any)   state_nxt = press_ok ? S_ECHO : S_FAIL;
        else if (t_done) state_nxt = S_FAIL;
      end
      S_ECHO: begin
        if (t_done) begin
          if (!last)             state_nxt = S_WAIT_IN;
          else if (len == MAX_L) state_nxt = S_WIN;
          else                   state_nxt = S_SUCCESS;
        end
      end
      S_SUCCESS:  if (t_done) state_nxt = S_ADD;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      timer <= '0;
      idx   <= '0;
      len   <= '0;
      score <= '0;
      high  <= '0;
      fast  <= 1'b0;
    end else begin
      state <= state_nxt;
      // Every state change restarts the tick timer, including each accepted press.
      if (state_nxt != state) timer <= '0;
      else if (tick)          timer <= timer + TW'(1);
      case (state)
        S_IDLE, S_FAIL, S_WIN: begin
          if (start) begin
            len   <= '0;
            score <= '0;
            fast  <= mode_fast;
          end
        end
        S_ADD: begin
          len <= len + 7'd1;
          idx <= '0;
        end
        S_SHOW_OFF: if (t_done) idx <= last ? 7'd0 : idx + 7'd1;
        S_ECHO: begin
          if (t_done) begin
            if (last) score <= len;
            else      idx   <= idx + 7'd1;
          end
        end
        default: ;
      endcase
      // On a win the score register updates in this same cycle, so compare len.
      if (state != S_FAIL && state_nxt == S_FAIL && score > high) high <= score;
      if (state != S_WIN && state_nxt == S_WIN && len > high)     high <= len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**PW; i++) pattern[i] <= '0;
    end else if (state == S_ADD) begin
      pattern[len[PW-1:0]] <= rnd[IDXW-1:0];
    end
  end

  always_comb begin
    game_leds = '0;
    case (state)
      S_SHOW_ON, S_ECHO: game_leds = cur_led;
      S_WIN:             game_leds = '1;
      default:           game_leds = '0;
    endcase
  end

  assign led_success = (state == S_SUCCESS) || (state == S_WIN);
  assign led_fail    = (state == S_FAIL);
  assign busy        = !((state == S_IDLE) || (state == S_FAIL) || (state == S_WIN));
  assign score_bcd   = to_bcd(score);
  assign high_bcd    = to_bcd(high);

endmodule

// File: tb/tb_simon_core_n.sv
// Directed bench for simon_core_n (4 buttons, 3-step maximum): playback/echo timing,
// fail paths, fast mode, win, high-score persistence and asynchronous reset.
module tb_simon_core_n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [3:0] btn_pulse;
  logic [7:0] rnd;
  logic       start;
  logic       mode_fast;
  logic [3:0] game_leds;
  logic       led_success;
  logic       led_fail;
  logic [7:0] score_bcd;
  logic [7:0] high_bcd;
  logic       busy;

  simon_core_n #(
    .NUM_BTNS(4), .MAX_LEN(3), .ON_TICKS(50), .OFF_TICKS(25),
    .TIMEOUT_TICKS(300), .RESULT_TICKS(100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn_pulse(btn_pulse), .rnd(rnd),
    .start(start), .mode_fast(mode_fast), .game_leds(game_leds),
    .led_success(led_success), .led_fail(led_fail), .score_bcd(score_bcd),
    .high_bcd(high_bcd), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rnd;
    logic [3:0] led;
    int         score;
  } round_t;

  round_t     tab_a [3];
  round_t     tab_w [3];
  logic [3:0] seq [3];
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Outputs are read just after the falling edge; tick is driven one clk in three.
  task automatic step();
    @(negedge clk);
    cyc++;
    tick = (cyc % 3 == 0);
  endtask

  function automatic logic [3:0] wrong(input logic [3:0] m);
    return {m[2:0], m[3]};
  endfunction

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      if (tick) k++;
      step();
    end
  endtask

  task automatic wait_lit(input string name);
    int g = 0;
    while (game_leds == 4'h0 && g < 2000) begin
      step();
      g++;
    end
    if (g >= 2000) check({name, "_wait"}, 0, 1);
  endtask

  // Counts ticks while the given LED pattern shows; a wrong press is poked in the first cycle.
  task automatic count_lit(input logic [3:0] exp, output int n);
    int g = 0;
    n = 0;
    btn_pulse = wrong(exp);
    while (game_leds == exp && g < 2000) begin
      if (tick) n++;
      step();
      btn_pulse = 4'h0;
      g++;
    end
    btn_pulse = 4'h0;
  endtask

  task automatic count_dark(output int n);
    int g = 0;
    n = 0;
    while (game_leds == 4'h0 && !led_fail && g < 3000) begin
      if (tick) n++;
      step();
      g++;
    end
  endtask

  task automatic play_step(input string name, input logic [3:0] exp, input int on_t);
    int n;
    wait_lit(name);
    check({name, "_led"}, int'(game_leds), int'(exp));
    count_lit(exp, n);
    check({name, "_ticks"}, n, on_t);
  endtask

  task automatic press(input logic [3:0] m);
    btn_pulse = m;
    step();
    btn_pulse = 4'h0;
  endtask

  task automatic do_start(input logic fast);
    start     = 1'b1;
    mode_fast = fast;
    step();
    start = 1'b0;
  endtask

  task automatic play_round(input int r, input int on_t, input int off_t, input int bad_at);
    int n;
    for (int i = 0; i <= r; i++) begin
      play_step("play", seq[i], on_t);
      if (i < r) begin
        count_dark(n);
        check("gap_ticks", n, off_t);
      end
    end
    press(wrong(seq[r]));
    wait_ticks(30);
    check("early_press_fail", int'(led_fail), 0);
    for (int i = 0; i <= r; i++) begin
      if (i == bad_at) begin
        press(wrong(seq[i]));
        return;
      end
      press(seq[i]);
      play_step("echo", seq[i], on_t);
    end
  endtask

  task automatic success_phase(input int exp_score);
    int n;
    int g = 0;
    check("succ_led", int'(led_success), 1);
    check("succ_score", int'(score_bcd), exp_score);
    n = 0;
    while (led_success && g < 2000) begin
      if (tick) n++;
      step();
      g++;
    end
    check("succ_ticks", n, 100);
  endtask

  initial begin
    int n;
    tab_a[0] = '{8'h02, 4'b0100, 8'h01};
    tab_a[1] = '{8'h05, 4'b0010, 8'h02};
    tab_a[2] = '{8'h07, 4'b1000, 8'h02};
    tab_w[0] = '{8'hF1, 4'b0010, 8'h01};
    tab_w[1] = '{8'h06, 4'b0100, 8'h02};
    tab_w[2] = '{8'h0F, 4'b1000, 8'h03};

    rst_n = 1'b0; tick = 1'b0; btn_pulse = 4'h0; rnd = 8'h00;
    start = 1'b0; mode_fast = 1'b0;
    step(); step();
    check("rst_leds", int'(game_leds), 0);
    check("rst_succ", int'(led_success), 0);
    check("rst_fail", int'(led_fail), 0);
    check("rst_score", int'(score_bcd), 0);
    check("rst_high", int'(high_bcd), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    step();
    press(4'b0100);
    check("idle_btn_busy", int'(busy), 0);

    // Normal game: two rounds pass, third round fails on its last step.
    rnd = tab_a[0].rnd;
    do_start(1'b0);
    check("start_busy", int'(busy), 1);
    for (int r = 0; r < 3; r++) begin
      seq[r] = tab_a[r].led;
      play_round(r, 50, 25, (r == 2) ? 2 : -1);
      if (r < 2) begin
        rnd = tab_a[r + 1].rnd;
        success_phase(tab_a[r].score);
      end
    end
    check("a_fail", int'(led_fail), 1);
    check("a_score", int'(score_bcd), 8'h02);
    check("a_high", int'(high_bcd), 8'h02);
    check("a_leds", int'(game_leds), 0);
    check("a_busy", int'(busy), 0);
    press(4'b0100);
    check("fail_btn_score", int'(score_bcd), 8'h02);

    // Timeout: 25 off-ticks plus 300 idle ticks in WAIT_IN.
    rnd = 8'h00;
    do_start(1'b0);
    check("to_score_clr", int'(score_bcd), 0);
    play_step("to_play", 4'b0001, 50);
    count_dark(n);
    check("to_ticks", n, 325);
    check("to_fail", int'(led_fail), 1);
    check("to_high", int'(high_bcd), 8'h02);

    // Two buttons at once with one of them correct.
    rnd = 8'h00;
    do_start(1'b0);
    play_step("mb_play", 4'b0001, 50);
    wait_ticks(30);
    check("mb_prefail", int'(led_fail), 0);
    press(4'b0011);
    check("mb_fail", int'(led_fail), 1);
    check("mb_score", int'(score_bcd), 0);

    // Asynchronous reset in the middle of playback.
    rnd = 8'h01;
    do_start(1'b0);
    wait_lit("rst_mid");
    step(); step();
    check("pre_rst_led", int'(game_leds), 4'b0010);
    rst_n = 1'b0;
    #1;
    check("mid_rst_leds", int'(game_leds), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_high", int'(high_bcd), 0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_succ", int'(led_success), 0);

    // Fast-mode game to a win; mode_fast drops right after start.
    rnd = tab_w[0].rnd;
    do_start(1'b1);
    mode_fast = 1'b0;
    for (int r = 0; r < 3; r++) begin
      seq[r] = tab_w[r].led;
      play_round(r, 25, 12, -1);
      if (r < 2) begin
        rnd = tab_w[r + 1].rnd;
        success_phase(tab_w[r].score);
      end
    end
    check("win_leds", int'(game_leds), 4'hF);
    check("win_succ", int'(led_success), 1);
    check("win_score", int'(score_bcd), 8'h03);
    check("win_high", int'(high_bcd), 8'h03);
    check("win_busy", int'(busy), 0);
    press(4'b0001);
    check("win_btn_leds", int'(game_leds), 4'hF);

    rnd = 8'h00;
    do_start(1'b0);
    check("restart_score", int'(score_bcd), 0);
    check("restart_high", int'(high_bcd), 8'h03);
    check("restart_busy", int'(busy), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
